// File: rtl/enemy_fire_ctrl.sv
// ---------------------------------------------------------------------------
// enemy_fire_ctrl
//
// Enemy-side shot controller. After a cooldown it walks the eight columns,
// starting at a pseudo-random column, looking for the lowest surviving enemy
// in each. The first one found launches a single projectile that falls
// toward the player. The projectile steps downward at a fixed rate, is
// tested against the player hitbox every enabled clock, and is drawn as a
// yellow rectangle for the top-level OR-mixer.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   enable        game running; low freezes FSM, counters and position
//   enemy_alive   24-bit alive mask, bit r*8+c = row r (0 = top), column c
//   col_x         packed 10-bit column X positions, column c at [c*10 +: 10]
//   row_y         packed 10-bit row Y positions, row r at [r*10 +: 10]
//   player_x      player ship left edge
//   player_alive  collision detection enabled only while high
//   h_counter     current VGA pixel column
//   v_counter     current VGA pixel row
//   shot_active   projectile in flight
//   shot_x        projectile top-left X
//   shot_y        projectile top-left Y
//   shooter_id    index (r*8+c) of the last enemy that fired
//   player_hit    one-clock pulse when the projectile strikes the player
//   R, G, B       projectile layer colour, one clock behind h/v_counter
// ---------------------------------------------------------------------------
module enemy_fire_ctrl #(
   parameter int FIRE_PERIOD = 50_000_000,
   parameter int STEP_PERIOD = 500_000,
   parameter int SHOT_SPEED  = 4,
   parameter int SCREEN_H    = 480,
   parameter int SPRITE_W    = 16,
   parameter int SPRITE_H    = 16,
   parameter int SHOT_W      = 2,
   parameter int SHOT_H      = 8,
   parameter int PLAYER_Y    = 440,
   parameter int PLAYER_W    = 32,
   parameter int PLAYER_H    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [23:0] enemy_alive,
   input  logic [79:0] col_x,
   input  logic [29:0] row_y,
   input  logic [10:0] player_x,
   input  logic        player_alive,
   input  logic [9:0]  h_counter,
   input  logic [9:0]  v_counter,
   output logic        shot_active,
   output logic [10:0] shot_x,
   output logic [10:0] shot_y,
   output logic [4:0]  shooter_id,
   output logic        player_hit,
   output logic [7:0]  R,
   output logic [7:0]  G,
   output logic [7:0]  B
);

   typedef enum logic [1:0] {IDLE, PICK, FLIGHT, HIT} state_t;

   localparam logic [31:0] FIRE_RELOAD = 32'(FIRE_PERIOD - 1);
   localparam logic [31:0] STEP_RELOAD = 32'(STEP_PERIOD - 1);
   localparam logic [10:0] X_OFF       = 11'(SPRITE_W / 2);
   localparam logic [10:0] Y_OFF       = 11'(SPRITE_H);
   localparam logic [10:0] SPEED       = 11'(SHOT_SPEED);
   localparam logic [10:0] BOTTOM      = 11'(SCREEN_H);
   localparam logic [10:0] SHOT_WL     = 11'(SHOT_W);
   localparam logic [10:0] SHOT_HL     = 11'(SHOT_H);
   localparam logic [10:0] PLAYER_WL   = 11'(PLAYER_W);
   localparam logic [10:0] PLY_TOP     = 11'(PLAYER_Y);
   localparam logic [10:0] PLY_BOT     = 11'(PLAYER_Y + PLAYER_H);

   state_t      state, state_nxt;
   logic [7:0]  lfsr;
   logic [31:0] cooldown, cooldown_nxt;
   logic [31:0] step_cnt, step_nxt;
   logic [2:0]  c0, c0_nxt;
   logic [2:0]  attempt, attempt_nxt;
   logic        active_nxt;
   logic [10:0] shot_x_nxt, shot_y_nxt;
   logic [4:0]  shooter_id_nxt;
   logic        player_hit_nxt;

   // Column scan: the column under test this clock and its lowest survivor.
   logic [2:0]  pick_col;
   logic [9:0]  col_x_arr [8];
   logic        col_found;
   logic [1:0]  row_sel;
   logic [9:0]  row_y_sel;

   assign pick_col = c0 + attempt;

   always_comb begin
      for (int c = 0; c < 8; c++) begin
         col_x_arr[c] = col_x[c*10 +: 10];
      end
   end

   // Bottom row wins: the lowest enemy in a column is the one that shoots.
   always_comb begin
      col_found = 1'b1;
      row_sel   = 2'd0;
      row_y_sel = row_y[9:0];
      if (enemy_alive[{2'd2, pick_col}]) begin
         row_sel   = 2'd2;
         row_y_sel = row_y[29:20];
      end else if (enemy_alive[{2'd1, pick_col}]) begin
         row_sel   = 2'd1;
         row_y_sel = row_y[19:10];
      end else if (!enemy_alive[{2'd0, pick_col}]) begin
         col_found = 1'b0;
      end
   end

   // Half-open box overlap between the registered shot and the player.
   logic [10:0] shot_r, shot_b, player_r, y_stepped;
   logic        hit_now, at_bottom;

   assign shot_r    = shot_x + SHOT_WL;
   assign shot_b    = shot_y + SHOT_HL;
   assign player_r  = player_x + PLAYER_WL;
   assign y_stepped = shot_y + SPEED;
   assign at_bottom = (y_stepped >= BOTTOM);
   assign hit_now   = player_alive
                    && (shot_x < player_r) && (player_x < shot_r)
                    && (shot_y < PLY_BOT)  && (PLY_TOP < shot_b);

   // LFSR x^8+x^6+x^5+x^4+1, free-running so the start column depends on
   // how long the game has been powered, not on how long it was enabled.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr <= 8'hA5;
      end else begin
         // NOTE: registers update with <= so every flop samples pre-edge values.
         lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cooldown    <= FIRE_RELOAD;
         step_cnt    <= '0;
         c0          <= '0;
         attempt     <= '0;
         shot_active <= 1'b0;
         shot_x      <= '0;
         shot_y      <= '0;
         shooter_id  <= '0;
         player_hit  <= 1'b0;
      end else begin
         state       <= state_nxt;
         cooldown    <= cooldown_nxt;
         step_cnt    <= step_nxt;
         c0          <= c0_nxt;
         attempt     <= attempt_nxt;
         shot_active <= active_nxt;
         shot_x      <= shot_x_nxt;
         shot_y      <= shot_y_nxt;
         shooter_id  <= shooter_id_nxt;
         player_hit  <= player_hit_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a hold default first, so no
      // path through the case can leave one unassigned and infer a latch.
      state_nxt      = state;
      cooldown_nxt   = cooldown;
      step_nxt       = step_cnt;
      c0_nxt         = c0;
      attempt_nxt    = attempt;
      active_nxt     = shot_active;
      shot_x_nxt     = shot_x;
      shot_y_nxt     = shot_y;
      shooter_id_nxt = shooter_id;
      player_hit_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               if (cooldown == '0) begin
                  state_nxt   = PICK;
                  c0_nxt      = lfsr[2:0];
                  attempt_nxt = '0;
               end else begin
                  cooldown_nxt = cooldown - 32'd1;
               end
            end
         end
         PICK: begin
            if (enable) begin
               if (col_found) begin
                  state_nxt      = FLIGHT;
                  active_nxt     = 1'b1;
                  shot_x_nxt     = {1'b0, col_x_arr[pick_col]} + X_OFF;
                  shot_y_nxt     = {1'b0, row_y_sel} + Y_OFF;
                  shooter_id_nxt = {row_sel, pick_col};
                  step_nxt       = STEP_RELOAD;
               end else if (attempt == 3'd7) begin
                  state_nxt    = IDLE;
                  cooldown_nxt = FIRE_RELOAD;
               end else begin
                  attempt_nxt = attempt + 3'd1;
               end
            end
         end
         FLIGHT: begin
            if (enable) begin
               // A hit outranks both stepping and leaving the screen.
               if (hit_now) begin
                  state_nxt      = HIT;
                  active_nxt     = 1'b0;
                  player_hit_nxt = 1'b1;
               end else if (step_cnt == '0) begin
                  step_nxt = STEP_RELOAD;
                  if (at_bottom) begin
                     active_nxt   = 1'b0;
                     state_nxt    = IDLE;
                     cooldown_nxt = FIRE_RELOAD;
                  end else begin
                     shot_y_nxt = y_stepped;
                  end
               end else begin
                  step_nxt = step_cnt - 32'd1;
               end
            end
         end
         HIT: begin
            // Leaves unconditionally so player_hit is never wider than one
            // clock, even if the game pauses on the very cycle of the hit.
            state_nxt    = IDLE;
            cooldown_nxt = FIRE_RELOAD;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Projectile layer; keeps drawing while the game is paused.
   logic [10:0] h_ext, v_ext;
   logic        in_box;

   assign h_ext  = {1'b0, h_counter};
   assign v_ext  = {1'b0, v_counter};
   assign in_box = shot_active
                 && (h_ext >= shot_x) && (h_ext < shot_r)
                 && (v_ext >= shot_y) && (v_ext < shot_b);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         R <= 8'h00;
         G <= 8'h00;
         B <= 8'h00;
      end else begin
         R <= in_box ? 8'hFF : 8'h00;
         G <= in_box ? 8'hFF : 8'h00;
         B <= 8'h00;
      end
   end

endmodule
